// File: rtl/memgen_pkg.sv
// memgen_pkg: shared types, limits and helpers for the memgen single-port controller.
//   state_e      - controller FSM states (INIT sweep, READY for requests)
//   RD_LAT_MIN/MAX - legal range of the read pipeline depth
//   even_parity  - even-parity bit over a zero-extended data word
package memgen_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned PAR_CALC_W = 64;

   // Bit that makes the total count of ones in {word, bit} even.
   function automatic logic even_parity(input logic [PAR_CALC_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/memgen_rd_pipe.sv
// memgen_rd_pipe: RD_LAT-deep read-return shift register with synchronous flush.
// Optional macro MEMGEN_PARITY_EN adds the in_err/out_err parity-error lane.
// Ports:
//   clock, reset          - clock and synchronous active-high flush
//   in_valid, in_data     - read accepted this cycle and its sampled word
//   in_err                - parity mismatch of the sampled word (parity builds)
//   out_valid, out_data   - one-cycle result strobe; data holds between strobes
//   out_err               - parity error qualified by out_valid (parity builds)
module memgen_rd_pipe
   import memgen_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
`ifdef MEMGEN_PARITY_EN
   input  logic              in_err,
   output logic              out_err,
`endif
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                 (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   logic [LAT-1:0]    vld_q;
   logic [DATA_W-1:0] dat_q [LAT];
`ifdef MEMGEN_PARITY_EN
   logic [LAT-1:0]    err_q;
`endif

   // Payload only moves behind a valid bit, so the last stage holds its word.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < int'(LAT); i++) dat_q[i] <= '0;
`ifdef MEMGEN_PARITY_EN
         err_q <= '0;
`endif
      end else begin
         vld_q[0] <= in_valid;
         if (in_valid) begin
            dat_q[0] <= in_data;
`ifdef MEMGEN_PARITY_EN
            err_q[0] <= in_err;
`endif
         end
         for (int i = 1; i < int'(LAT); i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
`ifdef MEMGEN_PARITY_EN
               err_q[i] <= err_q[i-1];
`endif
            end
         end
      end
   end

   assign out_valid = vld_q[LAT-1];
   assign out_data  = dat_q[LAT-1];
`ifdef MEMGEN_PARITY_EN
   assign out_err   = vld_q[LAT-1] & err_q[LAT-1];
`endif

endmodule

// File: rtl/memgen_sp_ctrl.sv
// memgen_sp_ctrl: parametrised single-port synchronous memory with a post-reset
// zero sweep, request handshake, per-bit write mask and pipelined read return.
// Optional macro MEMGEN_PARITY_EN adds a per-word even-parity bit and rd_err.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   chip_en             - request qualifier
//   wr_en, rd_en        - write / read request (read-before-write when both)
//   addr                - word address; addr >= DEPTH drops writes, reads zero
//   wr_data, wr_mask    - write word and per-bit enable (1 = bit written)
//   req_ready           - requests accepted this cycle
//   rd_data, rd_valid   - read result and its one-cycle strobe, RD_LAT after accept
//   rd_err              - stored parity mismatch, with rd_valid (parity builds)
//   init_done           - zero sweep complete
module memgen_sp_ctrl
   import memgen_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              chip_en,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] wr_mask,
   output logic              req_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
`ifdef MEMGEN_PARITY_EN
   output logic              rd_err,
`endif
   output logic              init_done
);

   // One extra counter bit keeps the terminal compare from wrapping.
   localparam int unsigned     CNT_W      = ADDR_W + 1;
   localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  sweep_q, sweep_d;
   logic              ready_q, ready_d;
   logic              init_wr_c, addr_ok_c, acc_c, wr_fire_c, rd_fire_c;
   logic [DATA_W-1:0] rd_word_c, wr_word_c;
   logic [DATA_W-1:0] mem [DEPTH];

   // Address range check only exists when the array does not fill the address space.
   if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
      assign addr_ok_c = 1'b1;
   end else begin : g_part_range
      assign addr_ok_c = (CNT_W'(addr) < CNT_W'(DEPTH));
   end

   // FSM and sweep counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT;
         sweep_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         ready_q <= ready_d;
      end
   end

   // Next state: sweep one word per cycle, then serve requests until reset.
   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      ready_d   = 1'b0;
      init_wr_c = 1'b0;
      unique case (state_q)
         INIT: begin
            init_wr_c = ~reset;
            sweep_d   = sweep_q + CNT_W'(1);
            if (sweep_q == SWEEP_LAST) begin
               state_d = READY;
               ready_d = 1'b1;
            end
         end
         READY:   ready_d = 1'b1;
         default: state_d = INIT;
      endcase
   end

   assign req_ready = ready_q;
   assign init_done = ready_q;

   assign acc_c     = ready_q & chip_en & ~reset;
   assign wr_fire_c = acc_c & wr_en & addr_ok_c & (|wr_mask);
   assign rd_fire_c = acc_c & rd_en;
   assign wr_word_c = (mem[addr] & ~wr_mask) | (wr_data & wr_mask);
   assign rd_word_c = addr_ok_c ? mem[addr] : '0;

   // Storage: sweep zeroes and masked writes share the single port.
   always_ff @(posedge clock) begin
      if (init_wr_c)      mem[sweep_q[ADDR_W-1:0]] <= '0;
      else if (wr_fire_c) mem[addr]                <= wr_word_c;
   end

`ifdef MEMGEN_PARITY_EN
   logic [DEPTH-1:0] par_mem;
   logic             rd_err_c;

   // Parity tracks the merged word so masked writes stay consistent.
   always_ff @(posedge clock) begin
      if (init_wr_c)      par_mem[sweep_q[ADDR_W-1:0]] <= 1'b0;
      else if (wr_fire_c) par_mem[addr] <= even_parity(PAR_CALC_W'(wr_word_c));
   end

   assign rd_err_c = addr_ok_c & (even_parity(PAR_CALC_W'(mem[addr])) != par_mem[addr]);
`endif

   memgen_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (rd_fire_c),
      .in_data   (rd_word_c),
`ifdef MEMGEN_PARITY_EN
      .in_err    (rd_err_c),
      .out_err   (rd_err),
`endif
      .out_valid (rd_valid),
      .out_data  (rd_data)
   );

endmodule

// File: tb/tb_memgen_sp_ctrl.sv
// Bench for memgen_sp_ctrl: a default instance (1024 words, latency 1) and a
// 1000-word latency-3 instance share one stimulus stream; each is compared
// against its own reference model every cycle.
module tb_memgen_sp_ctrl;

   localparam int N = 8;

   logic        clock = 1'b0;
   logic        reset, chip_en, wr_en, rd_en;
   logic [9:0]  addr;
   logic [15:0] wr_data, wr_mask;

   logic        a_ready, a_valid, a_done, b_ready, b_valid, b_done;
   logic [15:0] a_data, b_data;
   logic        obs_v [2], obs_r [2], obs_i [2];
   logic [15:0] obs_d [2];
`ifdef MEMGEN_PARITY_EN
   logic        a_err, b_err;
   logic        obs_e [2];
   assign obs_e[0] = a_err;
   assign obs_e[1] = b_err;
`endif

   assign obs_v[0] = a_valid;  assign obs_v[1] = b_valid;
   assign obs_d[0] = a_data;   assign obs_d[1] = b_data;
   assign obs_r[0] = a_ready;  assign obs_r[1] = b_ready;
   assign obs_i[0] = a_done;   assign obs_i[1] = b_done;

   always #5 clock = ~clock;

   memgen_sp_ctrl dut_a (
      .clock(clock), .reset(reset), .chip_en(chip_en), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .wr_mask(wr_mask), .req_ready(a_ready),
      .rd_data(a_data), .rd_valid(a_valid),
`ifdef MEMGEN_PARITY_EN
      .rd_err(a_err),
`endif
      .init_done(a_done));

   memgen_sp_ctrl #(.DATA_W(16), .DEPTH(1000), .RD_LAT(3)) dut_b (
      .clock(clock), .reset(reset), .chip_en(chip_en), .wr_en(wr_en), .rd_en(rd_en),
      .addr(addr), .wr_data(wr_data), .wr_mask(wr_mask), .req_ready(b_ready),
      .rd_data(b_data), .rd_valid(b_valid),
`ifdef MEMGEN_PARITY_EN
      .rd_err(b_err),
`endif
      .init_done(b_done));

   // Reference model: word arrays plus a per-cycle table of due read results.
   int          depth_m [2] = '{1024, 1000};
   int          lat_m   [2] = '{1, 3};
   logic [15:0] mmem    [2][1024];
   bit          bad_par [2][1024];
   bit          rdy [2];
   int          cnt [2];
   bit          due_v [2][N];
   logic [15:0] due_d [2][N];
   bit          due_e [2][N];
   bit          exp_v [2];
   logic [15:0] exp_d [2];
   bit          exp_e [2];
   int          cyc = 0;
   int          n_pass = 0, n_checks = 0;

   function automatic void model_edge();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            rdy[k] = 0; cnt[k] = 0; exp_v[k] = 0; exp_d[k] = '0; exp_e[k] = 0;
            for (int j = 0; j < N; j++) due_v[k][j] = 0;
         end else begin
            int slot = (cyc + lat_m[k] - 1) % N;
            bit ok   = int'(addr) < depth_m[k];
            if (rdy[k] && chip_en) begin
               if (rd_en) begin
                  due_v[k][slot] = 1;
                  due_d[k][slot] = ok ? mmem[k][addr] : 16'h0;
                  due_e[k][slot] = ok && bad_par[k][addr];
               end
               if (wr_en && ok && wr_mask != 16'h0) begin
                  mmem[k][addr]    = (mmem[k][addr] & ~wr_mask) | (wr_data & wr_mask);
                  bad_par[k][addr] = 0;
               end
            end else if (!rdy[k]) begin
               cnt[k]++;
               if (cnt[k] == depth_m[k]) begin
                  rdy[k] = 1;
                  for (int j = 0; j < 1024; j++) begin mmem[k][j] = '0; bad_par[k][j] = 0; end
               end
            end
            exp_v[k] = due_v[k][cyc % N];
            if (exp_v[k]) begin exp_d[k] = due_d[k][cyc % N]; exp_e[k] = due_e[k][cyc % N]; end
            else exp_e[k] = 0;
            due_v[k][cyc % N] = 0;
         end
      end
      cyc++;
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit ce, input bit we, input bit re, input int a,
                        input logic [15:0] d, input logic [15:0] m);
      chip_en = ce; wr_en = we; rd_en = re; addr = 10'(a); wr_data = d; wr_mask = m;
   endtask

   task automatic test_reset();
      int a_first = -1, b_first = -1;
      reset = 1'b1;
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      tick(); tick();
      for (int k = 0; k < 2; k++) begin
         if ({obs_v[k], obs_d[k], obs_r[k], obs_i[k]} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state dut%0d got v=%b d=%h rdy=%b done=%b want all zero",
                     k, obs_v[k], obs_d[k], obs_r[k], obs_i[k]);
         end else n_pass++;
         n_checks++;
      end
      reset = 1'b0;
      for (int i = 1; i <= 1024; i++) begin
         tick();
         if (a_ready && a_first < 0) a_first = i;
         if (b_ready && b_first < 0) b_first = i;
         for (int k = 0; k < 2; k++) begin
            if ({obs_v[k], obs_d[k], obs_r[k], obs_i[k]} !== {exp_v[k], exp_d[k], rdy[k], rdy[k]}) begin
               $display("FAIL sweep dut%0d cyc=%0d got v=%b d=%h rdy=%b done=%b want v=%b d=%h rdy=%b",
                        k, i, obs_v[k], obs_d[k], obs_r[k], obs_i[k], exp_v[k], exp_d[k], rdy[k]);
            end else n_pass++;
            n_checks++;
         end
      end
      if (a_first !== 1024) $display("FAIL sweep_len_a got %0d want 1024", a_first);
      else n_pass++;
      n_checks++;
      if (b_first !== 1000) $display("FAIL sweep_len_b got %0d want 1000", b_first);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_idle_read();
      for (int i = 0; i < 14; i++) begin
         if (i < 10) drive(1, 0, 1, int'($urandom_range(0, 1023)), 16'h0, 16'h0);
         else        drive(0, 0, 0, 0, 16'h0, 16'h0);
         tick();
         for (int k = 0; k < 2; k++) begin
            if ({obs_v[k], obs_d[k]} !== {exp_v[k], 16'h0}) begin
               $display("FAIL idle_read dut%0d got v=%b d=%h want v=%b d=0000",
                        k, obs_v[k], obs_d[k], exp_v[k]);
            end else n_pass++;
            n_checks++;
         end
      end
   endtask

   task automatic test_write_read();
      drive(1, 1, 0, 'h3FF, 16'hA5C3, 16'hFFFF); tick();
      drive(1, 0, 1, 'h3FF, 16'h0, 16'h0);       tick();
      if ({a_valid, a_data} !== {1'b1, 16'hA5C3})
         $display("FAIL wr_rd_pulse got v=%b d=%h want v=1 d=a5c3", a_valid, a_data);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick();
      if ({a_valid, a_data} !== {1'b0, 16'hA5C3})
         $display("FAIL wr_rd_hold got v=%b d=%h want v=0 d=a5c3", a_valid, a_data);
      else n_pass++;
      n_checks++;
      tick();
      // 0x3FF is beyond the 1000-word instance: its read returns zero.
      if ({b_valid, b_data} !== {1'b1, 16'h0})
         $display("FAIL oob_3ff_b got v=%b d=%h want v=1 d=0000", b_valid, b_data);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_masked_write();
      drive(1, 1, 0, 5, 16'h1234, 16'hFFFF); tick();
      drive(1, 1, 0, 5, 16'hFFFF, 16'h00F0); tick();
      drive(1, 1, 0, 5, 16'h0000, 16'h0000); tick();
      drive(1, 0, 1, 5, 16'h0, 16'h0);       tick();
      if ({a_valid, a_data} !== {1'b1, 16'h12F4})
         $display("FAIL masked_write got v=%b d=%h want v=1 d=12f4", a_valid, a_data);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick(); tick();
      if ({b_valid, b_data} !== {1'b1, 16'h12F4})
         $display("FAIL masked_write_b got v=%b d=%h want v=1 d=12f4", b_valid, b_data);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_read_before_write();
      drive(1, 1, 0, 7, 16'h0001, 16'hFFFF); tick();
      drive(1, 1, 1, 7, 16'hBEEF, 16'hFFFF); tick();
      if ({a_valid, a_data} !== {1'b1, 16'h0001})
         $display("FAIL rbw_old got v=%b d=%h want v=1 d=0001", a_valid, a_data);
      else n_pass++;
      n_checks++;
      drive(1, 0, 1, 7, 16'h0, 16'h0); tick();
      if ({a_valid, a_data} !== {1'b1, 16'hBEEF})
         $display("FAIL rbw_new got v=%b d=%h want v=1 d=beef", a_valid, a_data);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick(); tick(); tick();
   endtask

   task automatic test_pipeline_reset();
      logic [15:0] d [4];
      for (int a = 1; a <= 3; a++) begin
         d[a] = 16'($urandom);
         drive(1, 1, 0, a, d[a], 16'hFFFF); tick();
      end
      for (int a = 1; a <= 3; a++) begin
         drive(1, 0, 1, a, 16'h0, 16'h0); tick();
      end
      if ({b_valid, b_data} !== {1'b1, d[1]})
         $display("FAIL pipe_first got v=%b d=%h want v=1 d=%h", b_valid, b_data, d[1]);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick();
      if ({b_valid, b_data} !== {1'b1, d[2]})
         $display("FAIL pipe_second got v=%b d=%h want v=1 d=%h", b_valid, b_data, d[2]);
      else n_pass++;
      n_checks++;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({b_valid, b_ready, b_done} !== 3'b000)
            $display("FAIL pipe_flush cyc=%0d got v=%b rdy=%b done=%b want 000", i, b_valid, b_ready, b_done);
         else n_pass++;
         n_checks++;
      end
      reset = 1'b0;
      for (int i = 0; i < 1030; i++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if ({obs_v[k], obs_d[k], obs_r[k]} !== {exp_v[k], exp_d[k], rdy[k]}) begin
               $display("FAIL resweep dut%0d cyc=%0d got v=%b d=%h rdy=%b want v=%b d=%h rdy=%b",
                        k, i, obs_v[k], obs_d[k], obs_r[k], exp_v[k], exp_d[k], rdy[k]);
            end else n_pass++;
            n_checks++;
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [15:0] d = 16'($urandom) | 16'h0001;
      drive(1, 1, 0, 1010, d, 16'hFFFF); tick();
      drive(1, 0, 1, 1010, 16'h0, 16'h0); tick();
      if ({a_valid, a_data} !== {1'b1, d})
         $display("FAIL oob_a got v=%b d=%h want v=1 d=%h", a_valid, a_data, d);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick(); tick();
      if ({b_valid, b_data} !== {1'b1, 16'h0})
         $display("FAIL oob_b got v=%b d=%h want v=1 d=0000", b_valid, b_data);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         int sel = int'($urandom_range(0, 2));
         int a   = (sel == 0) ? int'($urandom_range(0, 15)) :
                   (sel == 1) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
         logic [15:0] m = ($urandom_range(0, 7) == 0) ? 16'h0 :
                          ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), a, 16'($urandom), m);
         tick();
         for (int k = 0; k < 2; k++) begin
            if ({obs_v[k], obs_d[k], obs_r[k]} !== {exp_v[k], exp_d[k], rdy[k]}) begin
               $display("FAIL random dut%0d cyc=%0d got v=%b d=%h rdy=%b want v=%b d=%h rdy=%b",
                        k, i, obs_v[k], obs_d[k], obs_r[k], exp_v[k], exp_d[k], rdy[k]);
            end else n_pass++;
            n_checks++;
`ifdef MEMGEN_PARITY_EN
            if (obs_e[k] !== exp_e[k])
               $display("FAIL random_err dut%0d cyc=%0d got %b want %b", k, i, obs_e[k], exp_e[k]);
            else n_pass++;
            n_checks++;
`endif
         end
      end
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      for (int i = 0; i < 4; i++) tick();
   endtask

`ifdef MEMGEN_PARITY_EN
   task automatic test_parity();
      drive(1, 1, 0, 9, 16'h0000, 16'hFFFF); tick();
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      force dut_b.par_mem[9] = 1'b1;
      bad_par[1][9] = 1;
      drive(1, 0, 1, 9, 16'h0, 16'h0); tick();
      if ({a_valid, a_err} !== 2'b10)
         $display("FAIL parity_clean_a got v=%b err=%b want v=1 err=0", a_valid, a_err);
      else n_pass++;
      n_checks++;
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick(); tick();
      if ({b_valid, b_err} !== 2'b11)
         $display("FAIL parity_inject got v=%b err=%b want v=1 err=1", b_valid, b_err);
      else n_pass++;
      n_checks++;
      release dut_b.par_mem[9];
      drive(1, 1, 0, 9, 16'h00C1, 16'hFFFF); tick();
      drive(1, 0, 1, 9, 16'h0, 16'h0); tick();
      drive(0, 0, 0, 0, 16'h0, 16'h0); tick(); tick();
      if ({b_valid, b_data, b_err} !== {1'b1, 16'h00C1, 1'b0})
         $display("FAIL parity_repair got v=%b d=%h err=%b want v=1 d=00c1 err=0", b_valid, b_data, b_err);
      else n_pass++;
      n_checks++;
   endtask
`endif

   initial begin
      test_reset();
      test_idle_read();
      test_write_read();
      test_masked_write();
      test_read_before_write();
      test_pipeline_reset();
      test_out_of_range();
      test_random();
`ifdef MEMGEN_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/memgen_sp_ctrl.md
Name: memgen_sp_ctrl

Overview:
Parametrised single-port synchronous memory block; successor to the fixed 16x1024 MemGen macro. Generalises data width, depth and read latency. Adds a post-reset zero-initialisation sweep, a ready/valid handshake, per-bit write masking and pipelined read data with a valid strobe. Instantiated in place of fixed MemGen macros inside chip-level wrappers.

Parameters:
DATA_W, 16, data word width in bits (1..64)
DEPTH, 1024, number of words (2..65536; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
RD_LAT, 1, read latency in cycles from accepted read to rd_valid (1..4)

Ports:
clock  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
chip_en  input  1  request qualifier; no access when low
wr_en  input  1  write request (with chip_en)
rd_en  input  1  read request (with chip_en)
addr  input  ADDR_W  word address
wr_data  input  DATA_W  write data
wr_mask  input  DATA_W  per-bit write enable; 1 = bit written
req_ready  output  1  block accepts requests this cycle
rd_data  output  DATA_W  read data; held until the next rd_valid
rd_valid  output  1  one-cycle pulse; rd_data valid
init_done  output  1  high once the zero sweep has completed

Behaviour:
- Reset (clock edge with reset=1): FSM->INIT, sweep counter=0, req_ready=0, rd_valid=0, rd_data=0, init_done=0, read pipeline flushed. Memory contents are not cleared in the reset cycle itself.
- FSM states: INIT, READY.
  - INIT: writes all-zero to address = sweep counter, one word per cycle. The counter runs 0..DEPTH-1, so the sweep takes exactly DEPTH cycles. After writing DEPTH-1: ->READY, init_done=1, req_ready=1 from the next cycle. Requests are ignored during INIT.
  - READY: req_ready=1 continuously. Stays in READY until reset.
- Accept rule: access occurs only when req_ready & chip_en; wr_en/rd_en are ignored otherwise.
- Write: mem[addr] <= (mem[addr] & ~wr_mask) | (wr_data & wr_mask). wr_mask=0 makes the write a no-op.
- Read: samples mem[addr] in the accept cycle. rd_valid pulses exactly RD_LAT cycles later, with rd_data updated in the same cycle.
  - rd_data holds its value when rd_valid=0.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Simultaneous wr_en & rd_en to the same address: read-before-write. Read returns the old contents; the write still takes effect.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of two):
  - write is dropped;
  - read returns all-zero with a normal rd_valid pulse.
- Reset mid-sweep: sweep restarts from 0. Reset with reads in flight: in-flight rd_valid pulses are discarded.
- Widths: the sweep counter is ADDR_W+1 bits wide so the terminal compare cannot wrap.

Optional Feature:
MEMGEN_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit over the stored data; the sweep writes parity 0.
  - A masked write recomputes parity over the merged word.
  - Adds output rd_err (1 bit). rd_err asserts with rd_valid when the stored parity mismatches. It is 0 for out-of-range reads and 0 at reset.
  - Bench hook: with MEMGEN_PARITY_EN defined, a hierarchical force on the parity array must be able to inject errors.
- Undefined: no parity storage and no rd_err port.

Decomposition:
- Package memgen_pkg: FSM state enum (INIT, READY); localparam limits for RD_LAT (min 1, max 4); parity helper function.
- One sub-module, memgen_rd_pipe: RD_LAT-deep shift register carrying valid, data and optional error bit, with synchronous flush on reset.
- The storage array and FSM live in memgen_sp_ctrl.

Test Plan:
- Reset, then idle with defaults (DEPTH=1024) -> req_ready=0 and init_done=0 for exactly 1024 cycles, both 1 on cycle 1025; a read of any address returns 0x0000.
- Write addr=0x3FF data=0xA5C3 mask=0xFFFF, then read 0x3FF (RD_LAT=1) -> rd_valid one cycle after the read, rd_data=0xA5C3, rd_valid low the following cycle.
- Write 0x1234 to addr 5, then masked write data=0xFFFF mask=0x00F0, then read -> 0x12F4.
- Same-cycle rd_en & wr_en to addr 7 (old 0x0001, new 0xBEEF) -> returned data 0x0001; a subsequent read returns 0xBEEF.
- RD_LAT=3, reads to addrs 1,2,3 on consecutive cycles -> three consecutive rd_valid pulses starting 3 cycles after the first read, data in order. Assert reset during the second pulse -> no further pulses, FSM in INIT.
- DEPTH=1000: write to addr 1010, then read 1010 -> rd_data=0, no array change. With MEMGEN_PARITY_EN, force a parity flip on addr 9 and read -> rd_err=1 coincident with rd_valid.
